red_pitaya_id_gen: RTL and testbench

Parametrised housekeeping/identification block, successor of the fixed 57-bit ID unit. Reads a device DNA of configurable width through an external DNA primitive interface with a programmable clock divider. Supports software-triggered re-read, exposes status, build ID, scratch and loopback-control registers on the system bus, and optionally a 64-bit uptime counter. Sits on the housekeeping slot of the system bus next to the other peripheral register banks.

---
 rtl/red_pitaya_id_gen.sv | 206 ++++++++++++++++++++
 tb/tb_red_pitaya_id_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_id_gen.sv
// red_pitaya_id_gen: housekeeping / identification register bank.
// Reads a DNA_W-bit device DNA through an external DNA primitive using a
// divided clock, and exposes ID, DNA, status, loopback, scratch and build
// registers on the system bus.
// Optional 64-bit uptime counter: define RP_ID_UPTIME_EN to include it.

module red_pitaya_id_gen #(
  parameter int          DNA_W    = 57,
  parameter int          DNA_DIV  = 4,
  parameter logic [3:0]  BOARD_ID = 4'h1,
  parameter logic [31:0] BUILD_ID = 32'h0,
  parameter int          LOOP_W   = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [LOOP_W-1:0] digital_loop,
  output logic              dna_clk_o,
  output logic              dna_read_o,
  output logic              dna_shift_o,
  input  logic              dna_dout_i,
  output logic              dna_valid_o,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam int CNT_W = (DNA_DIV > 1) ? $clog2(DNA_DIV) : 1;
  localparam int BIT_W = (DNA_W > 1) ? $clog2(DNA_W + 1) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DNA_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DNA_W - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   div_cnt;
  logic               phase;
  logic               tick;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DNA_W-1:0]   dna_value;
  logic [95:0]        dna_ext;
  logic               busy;
  logic               restart;
  logic [19:0]        reg_addr;
  logic [31:0]        scratch;
  logic [31:0]        rdata_next;
  logic [11:0]        unused_addr;

`ifdef RP_ID_UPTIME_EN
  logic [63:0]        uptime;
  logic [31:0]        uptime_shadow;
`endif

  assign reg_addr    = sys_addr[19:0];
  assign unused_addr = sys_addr[31:20];
  assign restart     = sys_wen && (reg_addr == 20'h00010) && sys_wdata[0];
  assign dna_ext     = 96'(dna_value);
  assign sys_err     = 1'b0;

  // One strobe per full dna_clk period, on the last cycle of its high phase,
  // so READ is held across a complete rising edge before moving on.
  assign tick = (div_cnt == DIV_LAST) && phase && (state != ST_DONE);

  // Clock divider for the DNA primitive; parked at zero once the read is done.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (restart || (state == ST_DONE)) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // FSM state register; a restart request forces a fresh load.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_LOAD;
    end else if (restart) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic: load once, then shift DNA_W bits, then hold.
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:  if (tick) next_state = ST_SHIFT;
      ST_SHIFT: if (tick && (bit_cnt == BIT_LAST)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_DONE;
      default:  next_state = ST_LOAD;
    endcase
  end

  // FSM outputs driving the DNA primitive and status bits.
  always_comb begin
    dna_read_o  = 1'b0;
    dna_shift_o = 1'b0;
    dna_valid_o = 1'b0;
    busy        = 1'b0;
    dna_clk_o   = phase && (state != ST_DONE);
    case (state)
      ST_LOAD: begin
        dna_read_o = 1'b1;
        busy       = 1'b1;
      end
      ST_SHIFT: begin
        dna_shift_o = 1'b1;
        busy        = 1'b1;
      end
      ST_DONE: dna_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Shift DNA in MSB first and count captured bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dna_value <= '0;
      bit_cnt   <= '0;
    end else if (restart) begin
      dna_value <= '0;
      bit_cnt   <= '0;
    end else if ((state == ST_SHIFT) && tick) begin
      dna_value <= (dna_value << 1) | DNA_W'(dna_dout_i);
      bit_cnt   <= bit_cnt + BIT_W'(1);
    end
  end

  // Software-writable loopback and scratch registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      digital_loop <= '0;
      scratch      <= '0;
    end else if (sys_wen) begin
      case (reg_addr)
        20'h00014: digital_loop <= sys_wdata[LOOP_W-1:0];
        20'h00018: scratch      <= sys_wdata;
        default: ;
      endcase
    end
  end

`ifdef RP_ID_UPTIME_EN
  // Free-running uptime; reading the low word freezes the high word so the
  // pair reads coherently even across a carry.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      uptime        <= '0;
      uptime_shadow <= '0;
    end else begin
      uptime <= uptime + 64'd1;
      if (sys_ren && (reg_addr == 20'h00020)) begin
        uptime_shadow <= uptime[63:32];
      end
    end
  end
`endif

  // Read decode; DNA words stay hidden until the value is complete.
  always_comb begin
    rdata_next = 32'h0;
    case (reg_addr)
      20'h00000: rdata_next = {24'h0, 4'h2, BOARD_ID};
      20'h00004: rdata_next = dna_valid_o ? dna_ext[31:0]  : 32'h0;
      20'h00008: rdata_next = dna_valid_o ? dna_ext[63:32] : 32'h0;
      20'h0000C: rdata_next = dna_valid_o ? dna_ext[95:64] : 32'h0;
      20'h00010: rdata_next = {30'h0, busy, dna_valid_o};
      20'h00014: rdata_next = 32'(digital_loop);
      20'h00018: rdata_next = scratch;
      20'h0001C: rdata_next = BUILD_ID;
`ifdef RP_ID_UPTIME_EN
      20'h00020: rdata_next = uptime[31:0];
      20'h00024: rdata_next = uptime_shadow;
`endif
      default:   rdata_next = 32'h0;
    endcase
  end

  // Registered bus response: every access is acknowledged one cycle later.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= 32'h0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_red_pitaya_id_gen.sv
// Testbench for red_pitaya_id_gen: two instances (57-bit and 96-bit DNA),
// each fed by a simple DNA primitive stub, with a bus scoreboard.

module tb_red_pitaya_id_gen;

  localparam logic [56:0] DNA_A   = 57'h0823456789ABCDE;
  localparam logic [95:0] DNA_B   = 96'hA5A5_A5A5_5A5A_5A5A_0123_4567;
  localparam logic [31:0] BUILD_A = 32'hCAFE_0001;

  logic        clk_i  = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] sys_addr  = 32'h0;
  logic [31:0] sys_wdata = 32'h0;
  logic        wen_a = 1'b0, ren_a = 1'b0, wen_b = 1'b0, ren_b = 1'b0;

  logic [3:0]  loop_a;
  logic        dna_clk_a, dna_read_a, dna_shift_a, dna_dout_a, dna_valid_a;
  logic [31:0] rdata_a;
  logic        err_a, ack_a;

  logic [0:0]  loop_b;
  logic        dna_clk_b, dna_read_b, dna_shift_b, dna_dout_b, dna_valid_b;
  logic [31:0] rdata_b;
  logic        err_b, ack_b;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  logic [95:0] ext_a;
  logic [95:0] ext_b;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          chk;
  } sb_t;

  sb_t sb_a[$];
  sb_t sb_b[$];
  sb_t ent_a;
  sb_t ent_b;

  red_pitaya_id_gen #(
    .DNA_W(57), .DNA_DIV(4), .BOARD_ID(4'h1), .BUILD_ID(BUILD_A), .LOOP_W(4)
  ) u_dut_a (
    .clk_i(clk_i), .rstn_i(rstn_i), .digital_loop(loop_a),
    .dna_clk_o(dna_clk_a), .dna_read_o(dna_read_a), .dna_shift_o(dna_shift_a),
    .dna_dout_i(dna_dout_a), .dna_valid_o(dna_valid_a),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(wen_a), .sys_ren(ren_a),
    .sys_rdata(rdata_a), .sys_err(err_a), .sys_ack(ack_a)
  );

  red_pitaya_id_gen #(
    .DNA_W(96), .DNA_DIV(2), .BOARD_ID(4'h1), .BUILD_ID(32'h0), .LOOP_W(1)
  ) u_dut_b (
    .clk_i(clk_i), .rstn_i(rstn_i), .digital_loop(loop_b),
    .dna_clk_o(dna_clk_b), .dna_read_o(dna_read_b), .dna_shift_o(dna_shift_b),
    .dna_dout_i(dna_dout_b), .dna_valid_o(dna_valid_b),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(wen_b), .sys_ren(ren_b),
    .sys_rdata(rdata_b), .sys_err(err_b), .sys_ack(ack_b)
  );

  always #5 clk_i = ~clk_i;

  // Cycle count since reset release: cycle k is the interval after edge k.
  always @(posedge clk_i) begin
    if (!rstn_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // DNA primitive stubs: load while READ is high, shift on each falling
  // dna_clk edge that follows a high phase spent with SHIFT asserted.
  logic [56:0] stub_a = '0;
  logic [95:0] stub_b = '0;
  logic prev_clk_a = 1'b0, prev_shift_a = 1'b0;
  logic prev_clk_b = 1'b0, prev_shift_b = 1'b0;

  always @(negedge clk_i) begin
    if (dna_read_a) stub_a <= DNA_A;
    else if (prev_clk_a && !dna_clk_a && prev_shift_a) stub_a <= stub_a << 1;
    prev_clk_a   <= dna_clk_a;
    prev_shift_a <= dna_shift_a;
    if (dna_read_b) stub_b <= DNA_B;
    else if (prev_clk_b && !dna_clk_b && prev_shift_b) stub_b <= stub_b << 1;
    prev_clk_b   <= dna_clk_b;
    prev_shift_b <= dna_shift_b;
  end

  assign dna_dout_a = stub_a[56];
  assign dna_dout_b = stub_b[95];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboards: each acknowledge retires the oldest outstanding access.
  always @(negedge clk_i) begin
    if (ack_a) begin
      checkOutput("sb_a_pending", 64'(sb_a.size() > 0), 64'd1);
      if (sb_a.size() > 0) begin
        ent_a = sb_a.pop_front();
        if (ent_a.chk) checkOutput(ent_a.tag, 64'(rdata_a), 64'(ent_a.exp));
      end
    end
    if (ack_b) begin
      checkOutput("sb_b_pending", 64'(sb_b.size() > 0), 64'd1);
      if (sb_b.size() > 0) begin
        ent_b = sb_b.pop_front();
        if (ent_b.chk) checkOutput(ent_b.tag, 64'(rdata_b), 64'(ent_b.exp));
      end
    end
  end

  task automatic applyStimulus(input bit to_b, input bit wr, input bit rd,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] exp, input string tag);
    sb_t ent;
    ent.tag = tag;
    ent.exp = exp;
    ent.chk = rd;
    sys_addr  = addr;
    sys_wdata = data;
    if (to_b) begin
      wen_b = wr; ren_b = rd; sb_b.push_back(ent);
    end else begin
      wen_a = wr; ren_a = rd; sb_a.push_back(ent);
    end
    @(negedge clk_i);
    wen_a = 1'b0; ren_a = 1'b0; wen_b = 1'b0; ren_b = 1'b0;
    checkOutput({tag, "_ack"}, 64'(to_b ? ack_b : ack_a), 64'd1);
  endtask

  task automatic readA(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, 32'h0, exp, tag);
  endtask

  task automatic writeA(input logic [31:0] addr, input logic [31:0] data, input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, data, 32'h0, tag);
  endtask

  task automatic readB(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, 32'h0, exp, tag);
  endtask

  task automatic waitUntil(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ext_a = {39'h0, DNA_A};
    ext_b = DNA_B;

    repeat (3) @(negedge clk_i);
    checkOutput("rst_valid_a", 64'(dna_valid_a), 64'd0);
    checkOutput("rst_valid_b", 64'(dna_valid_b), 64'd0);
    checkOutput("rst_ack_a",   64'(ack_a),       64'd0);
    checkOutput("rst_rdata_a", 64'(rdata_a),     64'd0);
    checkOutput("rst_loop_a",  64'(loop_a),      64'd0);
    checkOutput("rst_clk_a",   64'(dna_clk_a),   64'd0);
    checkOutput("rst_shift_a", 64'(dna_shift_a), 64'd0);
    checkOutput("rst_err_a",   64'(err_a),       64'd0);
    rstn_i = 1'b1;

    // Load phase: READ high for the first 8 cycles, dna_clk high in 4..7.
    waitUntil(0);
    checkOutput("c0_read",  64'(dna_read_a), 64'd1);
    checkOutput("c0_clk",   64'(dna_clk_a),  64'd0);
    waitUntil(3);
    checkOutput("c3_clk",   64'(dna_clk_a),  64'd0);
    waitUntil(4);
    checkOutput("c4_clk",   64'(dna_clk_a),  64'd1);
    checkOutput("c4_read",  64'(dna_read_a), 64'd1);
    waitUntil(7);
    checkOutput("c7_read",  64'(dna_read_a), 64'd1);
    waitUntil(8);
    checkOutput("c8_read",  64'(dna_read_a),  64'd0);
    checkOutput("c8_shift", 64'(dna_shift_a), 64'd1);
    checkOutput("c8_clk",   64'(dna_clk_a),   64'd0);

    // Mid-read: DNA hidden, status busy.
    waitUntil(200);
    readA(32'h04, 32'h0, "dna0_busy");
    readA(32'h10, 32'h2, "status_busy");

    // Loopback, scratch, read-only and unmapped registers.
    waitUntil(210);
    writeA(32'h14, 32'hFFFF_FFF5, "wr_loop");
    checkOutput("loop_out", 64'(loop_a), 64'h5);
    readA(32'h14, 32'h5, "rd_loop");
    writeA(32'h18, 32'hDEAD_BEEF, "wr_scratch");
    readA(32'h18, 32'hDEAD_BEEF, "rd_scratch");
    readA(32'h40, 32'h0, "rd_unmapped");
    writeA(32'h00, 32'hFFFF_FFFF, "wr_id");
    readA(32'h00, 32'h21, "rd_id");
    writeA(32'h1C, 32'h0, "wr_build");
    readA(32'h1C, BUILD_A, "rd_build");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h18, 32'h1234_5678, 32'hDEAD_BEEF, "wr_rd_same");
    @(negedge clk_i);
    checkOutput("ack_single", 64'(ack_a), 64'd0);
    readA(32'h18, 32'h1234_5678, "rd_scratch2");
`ifdef RP_ID_UPTIME_EN
    force u_dut_a.uptime = 64'h0000_0001_FFFF_FFFF;
    readA(32'h20, 32'hFFFF_FFFF, "uptime_lo");
    release u_dut_a.uptime;
    readA(32'h24, 32'h1, "uptime_hi_shadow");
`else
    readA(32'h20, 32'h0, "uptime_lo_off");
    readA(32'h24, 32'h0, "uptime_hi_off");
`endif

    // 96-bit instance, DNA_DIV=2: valid after 97*4 = 388 cycles.
    waitUntil(387);
    checkOutput("b_valid_387", 64'(dna_valid_b), 64'd0);
    waitUntil(388);
    checkOutput("b_valid_388", 64'(dna_valid_b), 64'd1);
    readB(32'h04, ext_b[31:0],  "b_dna0");
    readB(32'h08, ext_b[63:32], "b_dna1");
    readB(32'h0C, ext_b[95:64], "b_dna2");
    readB(32'h00, 32'h21,       "b_id");
    readB(32'h10, 32'h1,        "b_status");

    // 57-bit instance, DNA_DIV=4: valid after 58*8 = 464 cycles.
    waitUntil(463);
    checkOutput("a_valid_463", 64'(dna_valid_a), 64'd0);
    waitUntil(464);
    checkOutput("a_valid_464", 64'(dna_valid_a), 64'd1);
    checkOutput("a_done_read", 64'(dna_read_a),  64'd0);
    checkOutput("a_done_clk",  64'(dna_clk_a),   64'd0);
    readA(32'h04, ext_a[31:0],  "a_dna0");
    readA(32'h08, ext_a[63:32], "a_dna1");
    readA(32'h0C, ext_a[95:64], "a_dna2");
    readA(32'h10, 32'h1,        "a_status_done");

    // Restart from DONE.
    waitUntil(500);
    writeA(32'h10, 32'h1, "restart_done");
    checkOutput("r1_valid", 64'(dna_valid_a), 64'd0);
    checkOutput("r1_read",  64'(dna_read_a),  64'd1);
    waitUntil(510);
    readA(32'h10, 32'h2, "r1_status_busy");

    // Restart 300 cycles into the re-read, mid-SHIFT.
    waitUntil(800);
    readA(32'h04, 32'h0, "r1_dna0_hidden");
    writeA(32'h10, 32'h1, "restart_shift");
    checkOutput("r2_valid", 64'(dna_valid_a), 64'd0);
    checkOutput("r2_read",  64'(dna_read_a),  64'd1);
    checkOutput("r2_shift", 64'(dna_shift_a), 64'd0);
    waitUntil(1265);
    checkOutput("r2_valid_1265", 64'(dna_valid_a), 64'd0);
    waitUntil(1266);
    checkOutput("r2_valid_1266", 64'(dna_valid_a), 64'd1);
    readA(32'h04, ext_a[31:0],  "r2_dna0");
    readA(32'h08, ext_a[63:32], "r2_dna1");

    repeat (2) @(negedge clk_i);
    checkOutput("sb_a_drained", 64'(sb_a.size()), 64'd0);
    checkOutput("sb_b_drained", 64'(sb_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
